// File: rtl/obi_pkg.sv
// ============================================================================
// Module      : obi_pkg
// Description : Shared OBI bus widths and response metadata type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } obi_resp_meta_t;

endpackage

`default_nettype wire

// File: rtl/obi_resp_pipe.sv
// ============================================================================
// Module      : obi_resp_pipe
// Description : DEPTH-stage response delay line for metadata and read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_resp_pipe
    import obi_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  obi_resp_meta_t      meta_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output obi_resp_meta_t      meta_o,
    output logic [DATA_W-1:0]   rdata_o
);

    obi_resp_meta_t [DEPTH-1:0] r_meta;
    logic [DATA_W-1:0]          w_data_tail;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= '0;
        end else begin
            r_meta[0] <= meta_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_meta[i] <= r_meta[i-1];
            end
        end
    end

    // Read data arrives one cycle after the handshake, so it needs one stage fewer.
    generate
        if (DEPTH == 1) begin : g_direct
            assign w_data_tail = rdata_i;
        end else begin : g_stages
            logic [DEPTH-2:0][DATA_W-1:0] r_data;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_data <= '0;
                end else begin
                    r_data[0] <= rdata_i;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end

            assign w_data_tail = r_data[DEPTH-2];
        end
    endgenerate

    assign meta_o  = r_meta[DEPTH-1];
    assign rdata_o = (meta_o.valid && !meta_o.we && !meta_o.err) ? w_data_tail : '0;

endmodule

`default_nettype wire

// File: rtl/obi_sram_responder.sv
// ============================================================================
// Module      : obi_sram_responder
// Description : OBI subordinate front-end for an external single-port SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_sram_responder
    import obi_pkg::*;
#(
    parameter int  DEPTH_WORDS = 256,
    parameter int  GNT_WAIT    = 0,
    parameter int  RESP_LAT    = 1,
    localparam int SRAM_AW     = $clog2(DEPTH_WORDS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [BE_W-1:0]     be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                sram_en_o,
    output logic                sram_we_o,
    output logic [BE_W-1:0]     sram_be_o,
    output logic [SRAM_AW-1:0]  sram_addr_o,
    output logic [DATA_W-1:0]   sram_wdata_o,
    input  logic [DATA_W-1:0]   sram_rdata_i
);

    localparam logic [2:0] c_gnt_wait = 3'(GNT_WAIT);

    logic [2:0]     r_wait_cnt;
    logic           w_hs;
    logic           w_in_range;
    obi_resp_meta_t w_meta_in;
    obi_resp_meta_t w_meta_out;

    // Grant is held low while reset is asserted so nothing is accepted mid-reset.
    assign gnt_o      = req_i && rst_ni && (r_wait_cnt == c_gnt_wait);
    assign w_hs       = req_i && gnt_o;
    assign w_in_range = ({2'b00, addr_i[ADDR_W-1:2]} < 32'(DEPTH_WORDS));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (!req_i || w_hs) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end
    end

    assign sram_en_o    = w_hs && w_in_range;
    assign sram_we_o    = we_i;
    assign sram_be_o    = we_i ? be_i : '0;
    assign sram_addr_o  = addr_i[SRAM_AW+1:2];
    assign sram_wdata_o = wdata_i;

    assign w_meta_in = '{valid: w_hs, we: we_i, err: w_hs && !w_in_range};

    obi_resp_pipe #(
        .DEPTH (RESP_LAT)
    ) u_resp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .meta_i  (w_meta_in),
        .rdata_i (sram_rdata_i),
        .meta_o  (w_meta_out),
        .rdata_o (rdata_o)
    );

    assign rvalid_o = w_meta_out.valid;
    assign err_o    = w_meta_out.valid && w_meta_out.err;

endmodule

`default_nettype wire

// File: tb/tb_obi_sram_responder.sv
// ============================================================================
// Module      : tb_obi_sram_responder
// Description : Three responder configurations checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_sram_responder;

    localparam int DEPTH = 256;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [2:0]  req, we;
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [2:0]  gnt_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // cfg0: GNT_WAIT=0 RESP_LAT=1, cfg1: GNT_WAIT=3 RESP_LAT=1, cfg2: GNT_WAIT=0 RESP_LAT=3
    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int GW = (gi == 1) ? 3 : 0;
        localparam int RL = (gi == 2) ? 3 : 1;

        logic        gnt, rvalid, err, sen, swe;
        logic [31:0] rdata, swdata;
        logic [31:0] srdata = '0;
        logic [3:0]  sbe;
        logic [7:0]  saddr;
        logic [31:0] sram_mem [DEPTH];
        logic [31:0] ref_mem  [DEPTH];

        exp_t        q[$];
        int          rv_cyc[$];
        int          wcnt = 0;
        int          rv_count = 0;
        int          en_count = 0;
        logic [31:0] last_rdata = '0;
        logic        last_err = 1'b0;

        obi_sram_responder #(
            .DEPTH_WORDS (DEPTH),
            .GNT_WAIT    (GW),
            .RESP_LAT    (RL)
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .req_i        (req[gi]),
            .gnt_o        (gnt),
            .addr_i       (addr[gi]),
            .we_i         (we[gi]),
            .be_i         (be[gi]),
            .wdata_i      (wdata[gi]),
            .rvalid_o     (rvalid),
            .rdata_o      (rdata),
            .err_o        (err),
            .sram_en_o    (sen),
            .sram_we_o    (swe),
            .sram_be_o    (sbe),
            .sram_addr_o  (saddr),
            .sram_wdata_o (swdata),
            .sram_rdata_i (srdata)
        );

        assign gnt_v[gi] = gnt;

        initial begin
            for (int j = 0; j < DEPTH; j++) begin
                sram_mem[j] = '0;
                ref_mem[j]  = '0;
            end
        end

        // SRAM macro model: registered read, byte-masked write
        always @(posedge clk) begin
            if (sen) begin
                if (swe) begin
                    for (int b = 0; b < 4; b++)
                        if (sbe[b]) sram_mem[saddr][8*b +: 8] <= swdata[8*b +: 8];
                end else begin
                    srdata <= sram_mem[saddr];
                end
            end
        end

        always @(negedge clk) begin
            logic exp_g, inr, exp_rv;
            exp_t e;
            logic [7:0] idx;
            if (!rst_n) begin
                chk($sformatf("c%0d_rst_gnt", gi), gnt, 0);
                chk($sformatf("c%0d_rst_en", gi), sen, 0);
                chk($sformatf("c%0d_rst_rvalid", gi), rvalid, 0);
                chk($sformatf("c%0d_rst_err", gi), err, 0);
                chk($sformatf("c%0d_rst_rdata", gi), rdata, 0);
                q.delete();
                wcnt = 0;
            end else begin
                exp_g  = req[gi] && (wcnt == GW);
                inr    = (addr[gi][31:2] < DEPTH);
                exp_rv = (q.size() > 0) && (q[0].due == cyc);
                chk($sformatf("c%0d_gnt", gi), gnt, exp_g);
                chk($sformatf("c%0d_sram_en", gi), sen, exp_g && inr);
                if (exp_g && inr) begin
                    chk($sformatf("c%0d_sram_addr", gi), saddr, addr[gi][9:2]);
                    chk($sformatf("c%0d_sram_we", gi), swe, we[gi]);
                    chk($sformatf("c%0d_sram_be", gi), sbe, we[gi] ? be[gi] : 4'h0);
                    chk($sformatf("c%0d_sram_wdata", gi), swdata, wdata[gi]);
                end
                chk($sformatf("c%0d_rvalid", gi), rvalid, exp_rv);
                if (exp_rv) begin
                    e = q.pop_front();
                    chk($sformatf("c%0d_rdata", gi), rdata, e.data);
                    chk($sformatf("c%0d_err", gi), err, e.err);
                end else begin
                    chk($sformatf("c%0d_idle_rdata", gi), rdata, 0);
                    chk($sformatf("c%0d_idle_err", gi), err, 0);
                end
                if (rvalid) begin
                    rv_count++;
                    rv_cyc.push_back(cyc);
                    last_rdata = rdata;
                    last_err   = err;
                end
                if (sen) en_count++;
                if (exp_g) begin
                    idx    = addr[gi][9:2];
                    e.due  = cyc + RL;
                    e.err  = !inr;
                    e.data = (!we[gi] && inr) ? ref_mem[idx] : 32'h0;
                    q.push_back(e);
                    if (we[gi] && inr)
                        for (int b = 0; b < 4; b++)
                            if (be[gi][b]) ref_mem[idx][8*b +: 8] = wdata[gi][8*b +: 8];
                end
                wcnt = (req[gi] && !exp_g) ? wcnt + 1 : 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int k, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          output int waits, output int hcyc);
        logic got;
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        waits = 0; hcyc = -1; got = 1'b0;
        while (!got && waits <= 20) begin
            @(negedge clk);
            if (gnt_v[k]) begin
                got  = 1'b1;
                hcyc = cyc;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("c%0d_gnt_seen", k), got, 1);
        req[k] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, h, h0, n0, e0, sz;
        rst_n = 1'b0; req = '0; we = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; be[k] = '0; wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // cfg0: write, read, partial write, out-of-range read
        do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w, h);
        chk("c0_gnt_wait", w, 0);
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, w, h);
        idle(2);
        chk("c0_rd_data", g_cfg[0].last_rdata, 32'hDEADBEEF);
        chk("c0_rd_err", g_cfg[0].last_err, 0);
        do_req(0, 1'b1, 32'h10, 4'b0010, 32'h0000AB00, w, h);
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, w, h);
        idle(2);
        chk("c0_be_merge", g_cfg[0].last_rdata, 32'hDEADABEF);
        n0 = g_cfg[0].en_count;
        e0 = g_cfg[0].rv_count;
        do_req(0, 1'b0, 32'h400, 4'h0, 32'h0, w, h);
        idle(2);
        chk("c0_oor_err", g_cfg[0].last_err, 1);
        chk("c0_oor_rdata", g_cfg[0].last_rdata, 0);
        chk("c0_oor_no_en", g_cfg[0].en_count, n0);
        chk("c0_oor_one_rsp", g_cfg[0].rv_count, e0 + 1);

        // cfg1: grant after three wait cycles, then an abandoned request
        do_req(1, 1'b1, 32'h20, 4'hF, 32'h12345678, w, h);
        chk("c1_gnt_wait_wr", w, 3);
        do_req(1, 1'b0, 32'h20, 4'h0, 32'h0, w, h);
        chk("c1_gnt_wait_rd", w, 3);
        idle(2);
        chk("c1_rd_data", g_cfg[1].last_rdata, 32'h12345678);
        n0 = g_cfg[1].rv_count;
        e0 = g_cfg[1].en_count;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
        idle(2);
        req[1] = 1'b0;
        idle(4);
        chk("c1_abort_no_rsp", g_cfg[1].rv_count, n0);
        chk("c1_abort_no_en", g_cfg[1].en_count, e0);

        // cfg2: fill four words, then four back-to-back reads
        for (int k = 0; k < 4; k++)
            do_req(2, 1'b1, 32'(4 * k), 4'hF, 32'hA0000000 + 32'(k) * 32'h101, w, h);
        h0 = 0;
        for (int k = 0; k < 4; k++) begin
            do_req(2, 1'b0, 32'(4 * k), 4'h0, 32'h0, w, h);
            if (k == 0) h0 = h;
        end
        idle(6);
        sz = g_cfg[2].rv_cyc.size();
        chk("c2_first_rv_cycle", g_cfg[2].rv_cyc[sz-4], h0 + 3);
        for (int k = 1; k < 4; k++)
            chk($sformatf("c2_rv_consec%0d", k), g_cfg[2].rv_cyc[sz-4+k], h0 + 3 + k);
        chk("c2_last_data", g_cfg[2].last_rdata, 32'hA0000303);

        // cfg2: reset with one response on the bus and two still in flight
        for (int k = 0; k < 3; k++)
            do_req(2, 1'b0, 32'(4 * k), 4'h0, 32'h0, w, h);
        chk("c2_pre_rst_rvalid", g_cfg[2].rvalid, 1);
        #2 rst_n = 1'b0;
        #1 chk("c2_rst_async_rvalid", g_cfg[2].rvalid, 0);
        chk("c2_rst_async_rdata", g_cfg[2].rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n0 = g_cfg[2].rv_count;
        idle(6);
        chk("c2_post_rst_quiet", g_cfg[2].rv_count, n0);
        do_req(2, 1'b0, 32'h8, 4'h0, 32'h0, w, h);
        idle(5);
        chk("c2_post_rst_rsp", g_cfg[2].rv_count, n0 + 1);
        chk("c2_post_rst_data", g_cfg[2].last_rdata, 32'hA0000202);

        chk("c0_drain", g_cfg[0].q.size(), 0);
        chk("c1_drain", g_cfg[1].q.size(), 0);
        chk("c2_drain", g_cfg[2].q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
